// File: rtl/serpat_pkg.sv
// Shared constants, types and helpers for the serial pattern detector.
package serpat_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;

    // Fill counter only has to reach MAX_PAT_LEN-1.
    localparam int FILL_W = $clog2(MAX_PAT_LEN);
    typedef logic [FILL_W-1:0] fill_t;

    // Saturating increment of a counter that is `width` bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] maxv;
        maxv = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= maxv) ? maxv : (cnt + 32'd1);
    endfunction

endpackage

// File: rtl/serial_pattern_lane.sv
// One serial lane: bit history, fill tracking, match pulse and saturating match counter.
module serial_pattern_lane
    import serpat_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             linea,
    input  logic             valid,
    input  logic             clear_cnt,
    output logic             u,
    output logic [CNT_W-1:0] cnt
);

    localparam fill_t FILL_FULL = fill_t'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist;
    fill_t              fill;
    logic [PAT_LEN-1:0] cand;
    logic               hit;
    logic               u_p1;
    logic [CNT_W-1:0]   cnt_p1;

    // Candidate word and match decision for the bit offered this cycle.
    always_comb begin
        cand = {hist, linea};
        hit  = valid && (fill == FILL_FULL) && (cand == PATTERN);
    end

    // History and fill advance only on valid bits; a non-overlapping match restarts the search empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (valid) begin
            if (hit && (OVERLAP == 0)) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= cand[PAT_LEN-2:0];
                fill <= (fill == FILL_FULL) ? fill : fill + fill_t'(1);
            end
        end
    end

    // Stage 1: match pulse, high for the single cycle after the completing bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            u_p1 <= 1'b0;
        end else begin
            u_p1 <= hit;
        end
    end

    // Match counter; a clear coinciding with a match keeps that match as the first count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else if (clear_cnt) begin
            cnt_p1 <= hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            cnt_p1 <= CNT_W'(sat_inc(32'(cnt_p1), CNT_W));
        end
    end

    assign u   = u_p1;
    assign cnt = cnt_p1;

endmodule

// File: rtl/serial_pattern_detector.sv
// Multi-lane serial pattern detector: independent lanes, packed counters and a combined match flag.
module serial_pattern_detector
    import serpat_pkg::*;
#(
    parameter int                 LANES   = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LANES-1:0]       linea,
    input  logic [LANES-1:0]       valid,
    input  logic                   clear_cnt,
    output logic [LANES-1:0]       u,
    output logic [LANES*CNT_W-1:0] match_cnt,
    output logic                   any_match
);

    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_pat_len
        $error("serial_pattern_detector: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("serial_pattern_detector: CNT_W must be at least 1");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("serial_pattern_detector: LANES must be at least 1");
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_pattern_lane #(
            .PAT_LEN (PAT_LEN),
            .PATTERN (PATTERN),
            .OVERLAP (OVERLAP),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .linea     (linea[i]),
            .valid     (valid[i]),
            .clear_cnt (clear_cnt),
            .u         (u[i]),
            .cnt       (match_cnt[i*CNT_W +: CNT_W])
        );
    end

    // The lane pulses are flop outputs, so their OR is glitch-free and lines up with u.
    always_comb begin
        any_match = |u;
    end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench: three detector configurations driven by shared stimulus, checked against a queue-based model.
module tb_serial_pattern_detector;

    logic        clock;
    logic        reset;
    logic [3:0]  linea;
    logic [3:0]  valid;
    logic        clear_cnt;

    logic [3:0]  u0, u1, u2;
    logic [31:0] cnt0;
    logic [7:0]  cnt1, cnt2;
    logic        any0, any1, any2;

    int checks_total;
    int checks_passed;

    // Model configuration per instance: pattern value, overlap flag, counter maximum.
    int pat_v [3] = '{6, 5, 5};
    int ovl_v [3] = '{1, 1, 0};
    int cmax_v[3] = '{255, 3, 3};
    localparam int P = 4;

    bit hq [3][4][$];
    int exp_cnt [3][4];
    bit exp_u   [3][4];

    serial_pattern_detector dut0 (
        .clock(clock), .reset(reset), .linea(linea), .valid(valid), .clear_cnt(clear_cnt),
        .u(u0), .match_cnt(cnt0), .any_match(any0)
    );

    serial_pattern_detector #(.PATTERN(4'b0101), .OVERLAP(1), .CNT_W(2)) dut1 (
        .clock(clock), .reset(reset), .linea(linea), .valid(valid), .clear_cnt(clear_cnt),
        .u(u1), .match_cnt(cnt1), .any_match(any1)
    );

    serial_pattern_detector #(.PATTERN(4'b0101), .OVERLAP(0), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .linea(linea), .valid(valid), .clear_cnt(clear_cnt),
        .u(u2), .match_cnt(cnt2), .any_match(any2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic logic [3:0] get_u(input int k);
        case (k)
            0:       return u0;
            1:       return u1;
            default: return u2;
        endcase
    endfunction

    function automatic logic get_any(input int k);
        case (k)
            0:       return any0;
            1:       return any1;
            default: return any2;
        endcase
    endfunction

    function automatic logic [7:0] get_cnt(input int k, input int i);
        case (k)
            0:       return cnt0[i*8 +: 8];
            1:       return {6'd0, cnt1[i*2 +: 2]};
            default: return {6'd0, cnt2[i*2 +: 2]};
        endcase
    endfunction

    // Reference: keep the last P valid bits since the last restart; a match is a full window equal to the pattern.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                bit hit;
                int val;
                hit = 0;
                if (reset) begin
                    hq[k][i].delete();
                    exp_cnt[k][i] = 0;
                    exp_u[k][i]   = 0;
                end else begin
                    if (valid[i]) begin
                        hq[k][i].push_back(linea[i]);
                        if (hq[k][i].size() > P) void'(hq[k][i].pop_front());
                        if (hq[k][i].size() == P) begin
                            val = 0;
                            foreach (hq[k][i][j]) val = val * 2 + int'(hq[k][i][j]);
                            hit = (val == pat_v[k]);
                        end
                        if (hit && ovl_v[k] == 0) hq[k][i].delete();
                    end
                    exp_u[k][i] = hit;
                    if (clear_cnt)  exp_cnt[k][i] = hit ? 1 : 0;
                    else if (hit)   exp_cnt[k][i] = (exp_cnt[k][i] + 1 > cmax_v[k]) ? cmax_v[k] : exp_cnt[k][i] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eu;
            for (int i = 0; i < 4; i++) begin
                eu[i] = exp_u[k][i];
                chk($sformatf("dut%0d.cnt[%0d]", k, i), 32'(get_cnt(k, i)), 32'(exp_cnt[k][i]));
            end
            chk($sformatf("dut%0d.u", k), 32'(get_u(k)), 32'(eu));
            chk($sformatf("dut%0d.any", k), 32'(get_any(k)), 32'(|eu));
        end
    endtask

    task automatic step(input logic [3:0] lin, input logic [3:0] vld, input logic clr, input logic rst);
        @(negedge clock);
        linea     = lin;
        valid     = vld;
        clear_cnt = clr;
        reset     = rst;
        model_update();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic bit0(input logic b);
        step({3'b000, b}, 4'b0001, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(4'h0, 4'h0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset     = 1'b1;
        linea     = '0;
        valid     = '0;
        clear_cnt = 1'b0;

        // Reset state, including valid and clear asserted during reset.
        do_reset();
        step(4'hF, 4'hF, 1'b1, 1'b1);
        chk("reset.u0", 32'(u0), 32'h0);
        chk("reset.cnt0", cnt0, 32'h0);
        chk("reset.any0", 32'(any0), 32'h0);

        // Basic 0110 on lane 0.
        do_reset();
        bit0(0); bit0(1); bit0(1);
        chk("basic.pre", 32'(u0), 32'h0);
        bit0(0);
        chk("basic.u", 32'(u0), 32'h1);
        chk("basic.cnt", cnt0, 32'h0000_0001);
        chk("basic.any", 32'(any0), 32'h1);
        bit0(1);
        chk("basic.after", 32'(u0), 32'h0);

        // 010101 overlap vs non-overlap.
        do_reset();
        bit0(0); bit0(1); bit0(0); bit0(1);
        chk("ovl.p1.on", 32'(u1[0]), 32'h1);
        chk("ovl.p1.off", 32'(u2[0]), 32'h1);
        bit0(0);
        chk("ovl.b5.on", 32'(u1[0]), 32'h0);
        bit0(1);
        chk("ovl.p2.on", 32'(u1[0]), 32'h1);
        chk("ovl.p2.off", 32'(u2[0]), 32'h0);
        chk("ovl.cnt.on", 32'(cnt1[1:0]), 32'd2);
        chk("ovl.cnt.off", 32'(cnt2[1:0]), 32'd1);

        // Gaps in valid are transparent.
        do_reset();
        bit0(0); bit0(1);
        for (int g = 0; g < 3; g++) begin
            step(4'(g % 2 == 0 ? 4'hF : 4'h0), 4'h0, 1'b0, 1'b0);
            chk("gap.quiet", 32'(u0), 32'h0);
        end
        bit0(1); bit0(0);
        chk("gap.match", 32'(u0[0]), 32'h1);
        chk("gap.cnt", 32'(cnt0[7:0]), 32'd1);

        // Saturation at CNT_W=2, then clear interplay.
        do_reset();
        bit0(0); bit0(1);
        for (int m = 0; m < 5; m++) begin
            bit0(0); bit0(1);
            chk($sformatf("sat.cnt%0d", m), 32'(cnt1[1:0]), 32'((m + 1 > 3) ? 3 : m + 1));
        end
        bit0(0);
        step(4'h1, 4'h1, 1'b1, 1'b0);
        chk("clr.hit.u", 32'(u1[0]), 32'h1);
        chk("clr.hit.cnt", 32'(cnt1[1:0]), 32'd1);
        step(4'h0, 4'h0, 1'b1, 1'b0);
        chk("clr.nohit.cnt", 32'(cnt1[1:0]), 32'd0);

        // Simultaneous hits on lanes 0 and 2.
        do_reset();
        step(4'h0, 4'h5, 1'b0, 1'b0);
        step(4'h5, 4'h5, 1'b0, 1'b0);
        step(4'h5, 4'h5, 1'b0, 1'b0);
        step(4'h0, 4'h5, 1'b0, 1'b0);
        chk("multi.u", 32'(u0), 32'h5);
        chk("multi.any", 32'(any0), 32'h1);
        chk("multi.cnt", cnt0, 32'h0001_0001);
        step(4'h0, 4'h0, 1'b0, 1'b0);
        chk("multi.any.single", 32'(any0), 32'h0);

        // Reset in mid-pattern restarts the fill.
        do_reset();
        bit0(0); bit0(1); bit0(1);
        step(4'h0, 4'hF, 1'b0, 1'b1);
        chk("midrst.u", 32'(u0), 32'h0);
        bit0(0);
        chk("midrst.nomatch", 32'(u0), 32'h0);
        chk("midrst.cnt", cnt0, 32'h0);

        // Randomized traffic on all lanes.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rl, rv;
            logic       rc, rr;
            rl = 4'($urandom);
            rv = 4'($urandom) | 4'($urandom);
            rc = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 299) == 0);
            step(rl, rv, rc, rr);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
